// File: rtl/mips_muldiv_pkg.sv
// mips_muldiv_pkg: shared types and constants for the MIPS multiply/divide unit.
//   muldiv_op_e : operation codes carried on op_i (values 6 and 7 are reserved)
//   state_e     : sequencer states
//   ITERS       : iterations per multiply/divide (one result bit per cycle)
package mips_muldiv_pkg;

  typedef enum logic [2:0] {
    OpMult  = 3'd0,
    OpMultu = 3'd1,
    OpDiv   = 3'd2,
    OpDivu  = 3'd3,
    OpMthi  = 3'd4,
    OpMtlo  = 3'd5
  } muldiv_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFix
  } state_e;

  localparam int unsigned ITERS = 32;
  localparam int unsigned CntW  = $clog2(ITERS);

endpackage

// File: rtl/mips_muldiv_if.sv
// mips_muldiv_if: issue/result bundle between the core (master) and the muldiv unit (slave).
//   start_i    issue strobe, sampled only while busy_o=0
//   op_i       operation code (muldiv_op_e encoding; 6/7 reserved)
//   rs_data_i  operand A (multiplicand/dividend, MTHI/MTLO source)
//   rt_data_i  operand B (multiplier/divisor)
//   busy_o     operation in flight
//   done_o     one-cycle pulse after HI/LO were written by a multiply/divide
//   hi_o/lo_o  architectural HI/LO
interface mips_muldiv_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             start_i;
  logic [2:0]       op_i;
  logic [WIDTH-1:0] rs_data_i;
  logic [WIDTH-1:0] rt_data_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output start_i, op_i, rs_data_i, rt_data_i,
    input  busy_o, done_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, op_i, rs_data_i, rt_data_i,
    output busy_o, done_o, hi_o, lo_o
  );

endinterface

// File: rtl/mips_muldiv_abs.sv
// mips_muldiv_abs: combinational conditional two's-complement negate.
//   value_i  input value
//   neg_i    1: output -value_i, 0: output value_i unchanged
//   value_o  result
module mips_muldiv_abs #(
  parameter int unsigned Width = 32
) (
  input  logic [Width-1:0] value_i,
  input  logic             neg_i,
  output logic [Width-1:0] value_o
);

  always_comb begin
    value_o = value_i;
    if (neg_i) begin
      value_o = ~value_i + Width'(1);
    end
  end

endmodule

// File: rtl/mips_muldiv.sv
// mips_muldiv: iterative multiply/divide unit owning the MIPS HI/LO registers.
//   clk_i  clock, rising edge
//   rst_i  synchronous active-high reset
//   bus    mips_muldiv_if slave port (issue, busy/done, HI/LO)
// Multiply is radix-2 shift-add, divide is restoring shift-subtract, both on unsigned
// magnitudes; the sign is restored in a single FIX cycle.
module mips_muldiv
  import mips_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input logic            clk_i,
  input logic            rst_i,
  mips_muldiv_if.slave   bus
);

  localparam logic [CntW-1:0] CntLast = CntW'(ITERS - 1);

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;        // multiplicand, or dividend shifting out MSB-first
  logic [WIDTH-1:0]   b_q, b_d;        // multiplier shifting out LSB-first, or divisor
  logic [2*WIDTH-1:0] acc_q, acc_d;    // product, or {remainder, quotient}
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;  // negate product / quotient in FIX
  logic               neg_rem_q, neg_rem_d;  // negate remainder in FIX
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  // Issue decode
  logic             op_muldiv, op_signed, op_is_div, sign_a, sign_b;
  logic [WIDTH-1:0] a_abs, b_abs;

  assign op_muldiv = (bus.op_i == OpMult) || (bus.op_i == OpMultu) ||
                     (bus.op_i == OpDiv)  || (bus.op_i == OpDivu);
  assign op_signed = (bus.op_i == OpMult) || (bus.op_i == OpDiv);
  assign op_is_div = (bus.op_i == OpDiv)  || (bus.op_i == OpDivu);
  assign sign_a    = op_signed & bus.rs_data_i[WIDTH-1];
  assign sign_b    = op_signed & bus.rt_data_i[WIDTH-1];

  mips_muldiv_abs #(.Width(WIDTH)) u_abs_a (
    .value_i (bus.rs_data_i),
    .neg_i   (sign_a),
    .value_o (a_abs)
  );

  mips_muldiv_abs #(.Width(WIDTH)) u_abs_b (
    .value_i (bus.rt_data_i),
    .neg_i   (sign_b),
    .value_o (b_abs)
  );

  // Sign correction applied in FIX
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  mips_muldiv_abs #(.Width(2 * WIDTH)) u_fix_prod (
    .value_i (acc_q),
    .neg_i   (neg_res_q),
    .value_o (prod_fix)
  );

  mips_muldiv_abs #(.Width(WIDTH)) u_fix_quo (
    .value_i (acc_q[WIDTH-1:0]),
    .neg_i   (neg_res_q),
    .value_o (quo_fix)
  );

  mips_muldiv_abs #(.Width(WIDTH)) u_fix_rem (
    .value_i (acc_q[2*WIDTH-1:WIDTH]),
    .neg_i   (neg_rem_q),
    .value_o (rem_fix)
  );

  // One iteration of each algorithm
  logic [WIDTH:0] mul_sum, div_rem_sh, div_diff;

  always_comb begin
    mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (b_q[0] ? {1'b0, a_q} : '0);
    div_rem_sh = {acc_q[2*WIDTH-1:WIDTH], a_q[WIDTH-1]};
    // remainder < divisor, so bit WIDTH of the difference is a clean borrow flag
    div_diff   = div_rem_sh - {1'b0, b_q};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start_i) begin
          if (bus.op_i == OpMthi) begin
            hi_d = bus.rs_data_i;
          end else if (bus.op_i == OpMtlo) begin
            lo_d = bus.rs_data_i;
          end else if (op_muldiv) begin
            a_d       = a_abs;
            b_d       = b_abs;
            acc_d     = '0;
            cnt_d     = '0;
            is_div_d  = op_is_div;
            // Divide by zero keeps the all-ones quotient regardless of operand signs
            neg_res_d = (sign_a ^ sign_b) & ~(op_is_div & (bus.rt_data_i == '0));
            neg_rem_d = sign_a;
            state_d   = StRun;
          end
        end
      end

      StRun: begin
        if (is_div_q) begin
          a_d = a_q << 1;
          if (div_diff[WIDTH]) begin
            acc_d = {div_rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
          end else begin
            acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          end
        end else begin
          b_d   = b_q >> 1;
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          state_d = StFix;
        end
      end

      StFix: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy_o = (state_q != StIdle);
  assign bus.done_o = done_q;
  assign bus.hi_o   = hi_q;
  assign bus.lo_o   = lo_q;

endmodule

// File: tb/tb_mips_muldiv.sv
// tb_mips_muldiv: self-checking bench for mips_muldiv. Expected HI/LO come from a behavioural
// model and travel through a scoreboard queue from issue to the done_o pulse.
module tb_mips_muldiv;
  import mips_muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mips_muldiv_if #(.WIDTH(32)) bus ();

  mips_muldiv #(.WIDTH(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [63:0] sb_q[$];
  logic [31:0] hi_m, lo_m;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] r;
    int          sa, sb;
    sa = a;
    sb = b;
    r  = '0;
    case (op)
      3'd0: r = longint'(sa) * longint'(sb);
      3'd1: r = {32'd0, a} * {32'd0, b};
      3'd2: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
        else r = {32'(sa % sb), 32'(sa / sb)};
      end
      3'd3: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else r = {a % b, a / b};
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  // MTHI/MTLO or reserved op: update takes effect at the issue edge, never busy.
  task automatic mt_op(input string tag, input logic [2:0] op, input logic [31:0] val);
    if (op == 3'd4) hi_m = val;
    if (op == 3'd5) lo_m = val;
    @(negedge clk);
    bus.start_i   = 1'b1;
    bus.op_i      = op;
    bus.rs_data_i = val;
    bus.rt_data_i = ~val;
    @(negedge clk);
    bus.start_i = 1'b0;
    check({tag, " hilo"}, {bus.hi_o, bus.lo_o}, {hi_m, lo_m});
    check({tag, " busy/done"}, {62'd0, bus.busy_o, bus.done_o}, 64'd0);
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit perturb);
    int          cycles;
    logic [63:0] held, exp;
    sb_q.push_back(model(op, a, b));
    held = {bus.hi_o, bus.lo_o};
    @(negedge clk);
    bus.start_i   = 1'b1;
    bus.op_i      = op;
    bus.rs_data_i = a;
    bus.rt_data_i = b;
    @(negedge clk);
    bus.start_i = 1'b0;
    cycles = 0;
    while (bus.busy_o && cycles < 100) begin
      cycles++;
      if (perturb) begin
        bus.start_i   = 1'($urandom_range(0, 1));
        bus.op_i      = 3'($urandom_range(0, 7));
        bus.rs_data_i = $urandom;
        bus.rt_data_i = $urandom;
      end
      if (cycles == 16) check({tag, " hold"}, {bus.hi_o, bus.lo_o}, held);
      @(negedge clk);
    end
    bus.start_i = 1'b0;
    check({tag, " busy len"}, 64'(cycles), 64'd33);
    check({tag, " done"}, {63'd0, bus.done_o}, 64'd1);
    exp = sb_q.pop_front();
    check({tag, " result"}, {bus.hi_o, bus.lo_o}, exp);
    {hi_m, lo_m} = exp;
    @(negedge clk);
    check({tag, " done pulse"}, {63'd0, bus.done_o}, 64'd0);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        saw_done;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    rst           = 1'b1;
    bus.start_i   = 1'b0;
    bus.op_i      = 3'd0;
    bus.rs_data_i = '0;
    bus.rt_data_i = '0;
    hi_m          = '0;
    lo_m          = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset hilo", {bus.hi_o, bus.lo_o}, 64'd0);
    check("reset busy/done", {62'd0, bus.busy_o, bus.done_o}, 64'd0);

    mt_op("mthi", 3'd4, 32'h1234_5678);
    mt_op("mtlo", 3'd5, 32'h9ABC_DEF0);
    mt_op("rsvd6", 3'd6, 32'h5555_AAAA);
    mt_op("rsvd7", 3'd7, 32'hAAAA_5555);

    run_op("mult neg", 3'd0, 32'hFFFF_FFFD, 32'd7, 1'b0);
    run_op("multu max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op("mult m1", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op("div neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op("divu", 3'd3, 32'd100, 32'd7, 1'b0);
    run_op("div ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("divu zero", 3'd3, 32'hDEAD_BEEF, 32'd0, 1'b0);
    run_op("div zero", 3'd2, 32'hFFFF_FFF9, 32'd0, 1'b0);
    run_op("mult busy noise", 3'd0, 32'h0001_2345, 32'hFFFF_8001, 1'b1);
    run_op("div busy noise", 3'd2, 32'h7FFF_FFFF, 32'hFFFF_FFFD, 1'b1);

    for (int i = 0; i < 6; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i == 2) ? 32'd0 : $urandom;
      run_op("rand", rop, ra, rb, 1'(i % 2));
    end

    // Reset while RUN has count=10: result is discarded, no done pulse follows.
    @(negedge clk);
    bus.start_i   = 1'b1;
    bus.op_i      = 3'd0;
    bus.rs_data_i = 32'd5;
    bus.rt_data_i = 32'd6;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy/done", {62'd0, bus.busy_o, bus.done_o}, 64'd0);
    check("abort hilo", {bus.hi_o, bus.lo_o}, 64'd0);
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done_o || bus.busy_o) saw_done = 1'b1;
    end
    check("abort quiet", {63'd0, saw_done}, 64'd0);
    hi_m = '0;
    lo_m = '0;

    run_op("post reset divu", 3'd3, 32'd1000, 32'd33, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
